proc_mem_responder: RTL and testbench
=====================================

# proc_mem_responder

Synthesizable memory-side responder for the TinyRV1 `Proc` memory ports. It answers the processor's instruction-fetch and data requests from a single word-addressed RAM. It also exposes three memory-mapped registers: a cycle counter, a console FIFO push port, and a status register. The console FIFO drains through a valid/ready stream to an off-chip or testbench consumer. A separate load port fills the RAM before the processor is released from reset.

## Interface
- `MEM_WORDS`, default 256: RAM depth in 32-bit words; power of two, at most 16384.
- `FIFO_DEPTH`, default 4: console FIFO entries; power of two, at least 2.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imemreq_val`  in  1  fetch request valid.
- `imemreq_addr`  in  32  fetch byte address.
- `imemresp_data`  out  32  fetch data, combinational.
- `dmemreq_val`  in  1  data request valid.
- `dmemreq_type`  in  1  0 = read, 1 = write.
- `dmemreq_addr`  in  32  data byte address.
- `dmemreq_wdata`  in  32  write data.
- `dmemresp_rdata`  out  32  read data, combinational.
- `ld_val`  in  1  load-port write enable.
- `ld_addr`  in  32  load-port byte address; RAM region only.
- `ld_data`  in  32  load-port data.
- `cons_val`  out  1  console FIFO non-empty.
- `cons_data`  out  32  console FIFO head entry.
- `cons_rdy`  in  1  consumer accepts the head entry.

## Operation
- Address map; `addr[1:0]` is ignored everywhere.
  - RAM: `0x0000_0000` up to `4*MEM_WORDS-1`, word index `addr[2 +: log2(MEM_WORDS)]`.
  - CYCLE at `0x0001_0000`: read/write.
  - CONSOLE at `0x0001_0004`: write pushes; reads return 0.
  - STATUS at `0x0001_0008`. Bit0 = full, bit1 = empty, bit2 = overflow (sticky), bits[15:8] = occupancy count, other bits 0.
- Unmapped addresses, including RAM addresses at or beyond `4*MEM_WORDS`: reads return 0 and writes are ignored.
- `imemresp_data`: RAM word when `imemreq_val` is high and the address is in RAM, else 0. The fetch port never reads the MMIO registers.
- `dmemresp_rdata`: the selected word when `dmemreq_val` is high and `dmemreq_type` is 0, else 0.
- RAM writes come from a dmem write or from `ld_val`. If both target the same word in the same cycle, `ld_val` wins. If they target different words, both writes commit.
- CYCLE behaviour:
  - Increments by 1 every cycle and wraps modulo 2^32.
  - A dmem write sets the next value to exactly `wdata`, with no increment that cycle.
  - A read returns the current, pre-increment value.
- CONSOLE write:
  - If the FIFO is not full, or a pop happens in the same cycle, `wdata` is pushed at the tail.
  - Otherwise the data is dropped and overflow is set.
- STATUS write: `wdata[2]`=1 clears overflow; all other bits are ignored.
- Pop occurs when `cons_val && cons_rdy`. `cons_data` shows the head entry; its value is don't-care when the FIFO is empty.
- Simultaneous push and pop:
  - FIFO full: both take effect, occupancy is unchanged, overflow is not set.
  - FIFO empty: no pop occurs, because `cons_val` is 0.
- Reset:
  - CYCLE = 0, FIFO empty (pointers and count 0), overflow = 0, `cons_val` = 0.
  - `imemresp_data` and `dmemresp_rdata` are 0 when not requested.
  - RAM contents are not reset and persist across `rst`.
  - A reset asserted mid-operation discards FIFO contents immediately and asynchronously. A write in flight in that cycle is lost.

## Timing
- Reads have zero latency and are purely combinational from request inputs and current state.
- Writes commit at the next posedge and are visible to reads in the following cycle.
- A fetch of a word being written in the same cycle returns the old data.
- A console push becomes visible on `cons_val`/`cons_data` one cycle after the write cycle.
- A pop removes the head at the posedge. The next entry appears in the following cycle.
- STATUS reflects registered state before the current cycle's push or pop.
- CYCLE read at cycle k after reset deassertion returns k; the first posedge with `rst` low yields 1.

## Test plan
- **Load and fetch.** Load `0x00000013` at 0x0 and `0xDEADBEEF` at 0x3FC via the load port with `MEM_WORDS`=256, then release reset. Fetch 0x0 → `0x00000013`; fetch 0x3FC → `0xDEADBEEF`; fetch 0x400 → 0; `imemreq_val`=0 → 0.
- **Data read/write.** dmem write `0x12345678` to 0x10. Next cycle: read 0x10 → `0x12345678`; read 0x12 → `0x12345678`. A write to 0x0002_0000 followed by a read there → 0.
- **Counter.** Read CYCLE at 3 consecutive cycles → n, n+1, n+2. Write `0xFFFFFFFE`; next cycle read → `0xFFFFFFFE`; following cycle → `0xFFFFFFFF`; then 0 (wrap).
- **Console FIFO.** Hold `cons_rdy`=0 and push 1..5 with `FIFO_DEPTH`=4. STATUS then reads `0x00000405` (count 4, overflow, full). Raise `cons_rdy` → `cons_data` shows 1,2,3,4 on consecutive cycles, then `cons_val`=0 and STATUS reads `0x00000006`. Write STATUS `0x4` → reads `0x00000002`.
- **Full with simultaneous push and pop.** With the FIFO full (A,B,C,D) and `cons_rdy`=1, push E → no overflow. Drained order is A,B,C,D,E.
- **Reset mid-run.** With 2 entries queued and CYCLE at 50, pulse `rst` for 1 cycle between clock edges. Immediately `cons_val`=0 and CYCLE reads 0. A RAM word written earlier still reads its old value.

Source files
------------

// File: rtl/proc_mem_responder.sv
`timescale 1ns/1ps
// proc_mem_responder: memory-side responder for the TinyRV1 Proc ports.
// One word-addressed RAM serves fetch, data and load ports. Three MMIO
// registers (CYCLE, CONSOLE, STATUS) sit above the RAM region. The console
// FIFO drains through a valid/ready stream.
module proc_mem_responder #(
   parameter int unsigned MEM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemreq_val,
   input  logic [31:0] imemreq_addr,
   output logic [31:0] imemresp_data,
   input  logic        dmemreq_val,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   output logic [31:0] dmemresp_rdata,
   input  logic        ld_val,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        cons_val,
   output logic [31:0] cons_data,
   input  logic        cons_rdy
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   // MMIO word addresses (byte address >> 2)
   localparam logic [29:0] CYCLE_WA   = 30'h0000_4000;
   localparam logic [29:0] CONSOLE_WA = 30'h0000_4001;
   localparam logic [29:0] STATUS_WA  = 30'h0000_4002;

   logic [31:0]   ram  [MEM_WORDS];
   logic [31:0]   fifo [FIFO_DEPTH];
   logic [31:0]   cycle;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          overflow;

   logic          i_ram, d_ram, l_ram;
   logic [AW-1:0] i_idx, d_idx, l_idx;
   logic          d_rd, d_wr;
   logic          wr_ram, ld_ram, wr_cycle, wr_console, wr_status;
   logic          full, empty, push, pop;
   logic [31:0]   status;

   // Byte-offset bits are ignored by every port
   logic          unused_addr_bits;
   assign unused_addr_bits = ^{imemreq_addr[1:0], dmemreq_addr[1:0], ld_addr[1:0]};

   assign i_ram = (imemreq_addr[31:AW+2] == '0);
   assign d_ram = (dmemreq_addr[31:AW+2] == '0);
   assign l_ram = (ld_addr[31:AW+2] == '0);
   assign i_idx = imemreq_addr[2 +: AW];
   assign d_idx = dmemreq_addr[2 +: AW];
   assign l_idx = ld_addr[2 +: AW];

   assign d_rd = dmemreq_val && !dmemreq_type;
   assign d_wr = dmemreq_val &&  dmemreq_type;

   // dmem RAM writes are dropped while reset is held; the load port is not,
   // since it fills the RAM before the processor leaves reset
   assign wr_ram     = d_wr && d_ram && !rst;
   assign ld_ram     = ld_val && l_ram;
   assign wr_cycle   = d_wr && (dmemreq_addr[31:2] == CYCLE_WA);
   assign wr_console = d_wr && (dmemreq_addr[31:2] == CONSOLE_WA);
   assign wr_status  = d_wr && (dmemreq_addr[31:2] == STATUS_WA);

   assign full  = (count == (PW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign pop   = cons_val && cons_rdy;
   // A pop in the same cycle frees the slot a push into a full FIFO needs
   assign push  = wr_console && (!full || pop);

   assign cons_val  = !empty;
   assign cons_data = fifo[head];
   assign status    = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

   // Fetch port: RAM only, zero when idle or out of range
   always_comb begin
      imemresp_data = '0;
      if (imemreq_val && i_ram) imemresp_data = ram[i_idx];
   end

   // Data port read mux over RAM and readable MMIO registers
   always_comb begin
      dmemresp_rdata = '0;
      if (d_rd) begin
         if (d_ram)                                 dmemresp_rdata = ram[d_idx];
         else if (dmemreq_addr[31:2] == CYCLE_WA)   dmemresp_rdata = cycle;
         else if (dmemreq_addr[31:2] == STATUS_WA)  dmemresp_rdata = status;
      end
   end

   // RAM write ports; load port is ordered last so it wins a same-word collision
   always_ff @(posedge clk) begin
      if (wr_ram) ram[d_idx] <= dmemreq_wdata;
      if (ld_ram) ram[l_idx] <= ld_data;
   end

   // Free-running cycle counter, overwritten (without increment) by a dmem write
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cycle <= '0;
      else if (wr_cycle) cycle <= dmemreq_wdata;
      else               cycle <= cycle + 32'd1;
   end

   // Console FIFO storage; written at the tail on an accepted push
   always_ff @(posedge clk) begin
      if (push) fifo[tail] <= dmemreq_wdata;
   end

   // Console FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (wr_console && !push)              overflow <= 1'b1;
         else if (wr_status && dmemreq_wdata[2]) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_proc_mem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for proc_mem_responder: a driver issues directed and
// random requests, a queue-based reference model predicts every response,
// and a monitor on the falling edge compares DUT outputs against it.
module tb_proc_mem_responder;

   localparam int unsigned MW = 256;
   localparam int unsigned FD = 4;
   localparam logic [31:0] A_CYC  = 32'h0001_0000;
   localparam logic [31:0] A_CON  = 32'h0001_0004;
   localparam logic [31:0] A_STAT = 32'h0001_0008;

   logic        clk, rst;
   logic        imemreq_val;
   logic [31:0] imemreq_addr, imemresp_data;
   logic        dmemreq_val, dmemreq_type;
   logic [31:0] dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
   logic        ld_val;
   logic [31:0] ld_addr, ld_data;
   logic        cons_val, cons_rdy;
   logic [31:0] cons_data;

   proc_mem_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
      .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
      .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
      .ld_val(ld_val), .ld_addr(ld_addr), .ld_data(ld_data),
      .cons_val(cons_val), .cons_data(cons_data), .cons_rdy(cons_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state
   logic [31:0] ram_m [MW];
   logic [31:0] cyc_m;
   logic [31:0] fq [$];
   bit          ovf_m;

   // Scoreboard queues
   logic [31:0] iq [$];
   logic [31:0] dq [$];
   logic [31:0] cq [$];
   bit          vq [$];

   int checks = 0;
   int errors = 0;

   function automatic bit in_ram(input logic [31:0] a);
      return (a & 32'hFFFF_FFFC) < 32'(4 * MW);
   endfunction

   function automatic logic [31:0] status_m();
      int s;
      s = fq.size() * 256 + (ovf_m ? 4 : 0) + (fq.size() == 0 ? 2 : 0) + (fq.size() == FD ? 1 : 0);
      return 32'(s);
   endfunction

   function automatic logic [31:0] rd_m(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (in_ram(w))   return ram_m[w >> 2];
      if (w == A_CYC)  return cyc_m;
      if (w == A_STAT) return status_m();
      return 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Predict this cycle's outputs, advance the model over the coming edge,
   // then wait for that edge. r marks an edge at which reset is held.
   task automatic tick(input bit r);
      bit pop, full, wr;
      logic [31:0] w;
      if (imemreq_val && in_ram(imemreq_addr)) iq.push_back(ram_m[imemreq_addr >> 2]);
      else                                     iq.push_back(32'h0);
      dq.push_back((dmemreq_val && !dmemreq_type) ? rd_m(dmemreq_addr) : 32'h0);
      vq.push_back(fq.size() != 0);
      pop  = (fq.size() != 0) && cons_rdy;
      full = (fq.size() == FD);
      if (pop) cq.push_back(fq[0]);
      if (r) begin
         cyc_m = 32'h0;
         fq.delete();
         ovf_m = 1'b0;
      end else begin
         w  = dmemreq_addr & 32'hFFFF_FFFC;
         wr = dmemreq_val && dmemreq_type;
         cyc_m = (wr && w == A_CYC) ? dmemreq_wdata : cyc_m + 32'd1;
         if (pop) void'(fq.pop_front());
         if (wr && w == A_CON) begin
            if (!full || pop) fq.push_back(dmemreq_wdata);
            else              ovf_m = 1'b1;
         end
         if (wr && w == A_STAT && dmemreq_wdata[2]) ovf_m = 1'b0;
         if (wr && in_ram(w)) ram_m[w >> 2] = dmemreq_wdata;
      end
      if (ld_val && in_ram(ld_addr)) ram_m[ld_addr >> 2] = ld_data;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      imemreq_val = 1'b0; imemreq_addr = 32'h0;
      dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = 32'h0; dmemreq_wdata = 32'h0;
      ld_val = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
   endtask

   task automatic dwr(input logic [31:0] a, input logic [31:0] d);
      idle(); dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = a; dmemreq_wdata = d;
      tick(1'b0);
   endtask

   task automatic drd(input logic [31:0] a);
      idle(); dmemreq_val = 1'b1; dmemreq_addr = a;
      tick(1'b0);
   endtask

   task automatic fetch(input logic [31:0] a);
      idle(); imemreq_val = 1'b1; imemreq_addr = a;
      tick(1'b0);
   endtask

   task automatic nop();
      idle();
      tick(1'b0);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] lo;
      lo = 32'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
         0, 1, 2: return 32'($urandom_range(0, MW - 1)) * 32'd4 + lo;
         3:       return A_CYC + lo;
         4:       return A_CON + lo;
         5:       return A_STAT + lo;
         6:       return 32'(4 * MW) + 32'($urandom_range(0, 255)) * 32'd4 + lo;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every falling edge, compare outputs against the queued predictions
   always @(negedge clk) begin
      if (iq.size() == 0 || dq.size() == 0 || vq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: no prediction queued at %0t", $time);
      end else begin
         chk("imemresp_data", imemresp_data, iq.pop_front());
         chk("dmemresp_rdata", dmemresp_rdata, dq.pop_front());
         chk("cons_val", {31'b0, cons_val}, {31'b0, vq.pop_front()});
      end
      if (cons_val === 1'b1 && cons_rdy === 1'b1) begin
         if (cq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cons_pop: unexpected pop of 0x%08h at %0t", cons_data, $time);
         end else begin
            chk("cons_data", cons_data, cq.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cons_rdy = 1'b0; cyc_m = 32'h0; ovf_m = 1'b0;
      idle();
      @(posedge clk);
      #1;
      // Fill the whole RAM through the load port while reset is held
      for (int i = 0; i < int'(MW); i++) begin
         idle();
         ld_val  = 1'b1;
         ld_addr = 32'(i * 4);
         ld_data = (i == 0) ? 32'h0000_0013 : (i == int'(MW) - 1) ? 32'hDEAD_BEEF : $urandom;
         tick(1'b1);
      end
      idle();
      tick(1'b1);
      rst = 1'b0;

      // Load and fetch
      fetch(32'h0); fetch(32'h3FC); fetch(32'h400);
      idle(); imemreq_addr = 32'h0; tick(1'b0);

      // Data read/write, unmapped write
      dwr(32'h10, 32'h1234_5678); drd(32'h10); drd(32'h12);
      dwr(32'h0002_0000, 32'hCAFE_F00D); drd(32'h0002_0000);

      // Fetch of a word written in the same cycle sees old data
      idle(); imemreq_val = 1'b1; imemreq_addr = 32'h10;
      dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h10; dmemreq_wdata = 32'h55AA_55AA;
      tick(1'b0);
      fetch(32'h10);

      // Load port vs dmem write: same word, then different words
      idle(); dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h20; dmemreq_wdata = 32'h1111_1111;
      ld_val = 1'b1; ld_addr = 32'h20; ld_data = 32'h2222_2222; tick(1'b0);
      drd(32'h20);
      idle(); dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h24; dmemreq_wdata = 32'h3333_3333;
      ld_val = 1'b1; ld_addr = 32'h28; ld_data = 32'h4444_4444; tick(1'b0);
      drd(32'h24); drd(32'h28);

      // Counter and wrap
      drd(A_CYC); drd(A_CYC); drd(A_CYC);
      dwr(A_CYC, 32'hFFFF_FFFE);
      drd(A_CYC); drd(A_CYC); drd(A_CYC);

      // Console overflow, drain, overflow clear
      cons_rdy = 1'b0;
      for (int v = 1; v <= 5; v++) dwr(A_CON, 32'(v));
      drd(A_STAT);
      cons_rdy = 1'b1;
      repeat (4) nop();
      drd(A_STAT);
      dwr(A_STAT, 32'h4);
      drd(A_STAT);

      // Full FIFO with simultaneous push and pop
      cons_rdy = 1'b0;
      for (int v = 10; v <= 13; v++) dwr(A_CON, 32'(v));
      cons_rdy = 1'b1;
      dwr(A_CON, 32'd14);
      repeat (5) nop();
      drd(A_STAT);

      // Reset pulse between edges with entries queued
      cons_rdy = 1'b0;
      dwr(A_CYC, 32'd50); dwr(A_CON, 32'd7); dwr(A_CON, 32'd8);
      idle(); dmemreq_val = 1'b1; dmemreq_addr = A_CYC;
      rst = 1'b1; cyc_m = 32'h0; fq.delete(); ovf_m = 1'b0;
      fork
         begin #5; rst = 1'b0; end
      join_none
      tick(1'b0);
      drd(32'h10); drd(A_STAT);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         idle();
         cons_rdy      = ($urandom_range(0, 3) != 0);
         imemreq_val   = 1'($urandom_range(0, 1));
         imemreq_addr  = pick_addr();
         dmemreq_val   = ($urandom_range(0, 3) != 0);
         dmemreq_type  = 1'($urandom_range(0, 1));
         dmemreq_addr  = pick_addr();
         dmemreq_wdata = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            ld_val  = 1'b1;
            ld_addr = ($urandom_range(0, 1) != 0) ? (dmemreq_addr & 32'h0000_03FC)
                                                  : 32'($urandom_range(0, MW - 1)) * 32'd4;
            ld_data = $urandom;
         end
         tick(1'b0);
      end
      idle();
      cons_rdy = 1'b0;

      checks++;
      if (cq.size() != 0) begin
         errors++;
         $display("FAIL cons_drain: %0d predicted pops never seen, required 0", cq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
